// File: rtl/cmd_grant_arbiter.sv
// Round-robin command grant arbiter with a registered, ack-held one-hot grant.
// Optional starvation override is compiled in with the ARB_STARVE_GUARD_EN macro.
module cmd_grant_arbiter #(
  parameter int unsigned NUM_REQ      = 5,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req_i,
  input  logic                                         look_ahead,
  input  logic                                         grant_ack,
  output logic                                         grant_valid,
  output logic [NUM_REQ-1:0]                           grant_onehot,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] prio_ptr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REQ - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  if (NUM_REQ < 2 || STARVE_LIMIT < 1) begin : g_param_check
    $error("cmd_grant_arbiter: NUM_REQ must be >= 2 and STARVE_LIMIT >= 1");
  end

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   ptr_ack, scan_ptr, rr_idx, sel_idx;
  logic               arb_ok;

  assign ptr_ack  = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  // On an ack cycle the scan already uses the post-ack pointer so back-to-back grants rotate.
  assign scan_ptr = (state_q == StGrant) ? ptr_ack : ptr_q;
  assign arb_ok   = look_ahead && (|req_i);

  always_comb begin
    logic found;
    found  = 1'b0;
    rr_idx = scan_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [IDX_W-1:0] pos;
      pos = IDX_W'((32'(scan_ptr) + k) % NUM_REQ);
      if (!found && req_i[pos]) begin
        found  = 1'b1;
        rr_idx = pos;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_q [NUM_REQ];
  logic             starve_hit;
  logic [IDX_W-1:0] starve_idx;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!starve_hit && req_i[i] && (wait_q[i] == CntMax)) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!req_i[i] || (state_q == StGrant && grant_ack && idx_q == IDX_W'(i))) begin
          wait_q[i] <= '0;
        end else if (!(state_q == StGrant && idx_q == IDX_W'(i)) && wait_q[i] != CntMax) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  assign sel_idx = starve_hit ? starve_idx : rr_idx;
`else
  assign sel_idx = rr_idx;
`endif

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    case (state_q)
      StIdle: begin
        if (arb_ok) begin
          state_d  = StGrant;
          idx_d    = sel_idx;
          onehot_d = NUM_REQ'(1) << sel_idx;
        end
      end
      StGrant: begin
        if (grant_ack) begin
          ptr_d = ptr_ack;
          if (arb_ok) begin
            idx_d    = sel_idx;
            onehot_d = NUM_REQ'(1) << sel_idx;
          end else begin
            state_d  = StIdle;
            idx_d    = '0;
            onehot_d = '0;
          end
        end else if (!req_i[idx_q]) begin
          // Withdrawal: drop the grant, keep the pointer, no re-arbitration this cycle.
          state_d  = StIdle;
          idx_d    = '0;
          onehot_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        idx_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      onehot_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == StGrant);
  assign grant_onehot = onehot_q;
  assign grant_idx    = idx_q;
  assign prio_ptr     = ptr_q;

endmodule

// File: tb/tb_cmd_grant_arbiter.sv
// Scoreboard bench for cmd_grant_arbiter: stimulus queues expected outputs, a negedge monitor
// pops and compares. The starvation case follows ARB_STARVE_GUARD_EN if it is defined.
module tb_cmd_grant_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       look_ahead;
  logic       grant_ack;
  logic       grant_valid;
  logic [4:0] grant_onehot;
  logic [2:0] grant_idx;
  logic [2:0] prio_ptr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [4:0] oh;
    logic [2:0] idx;
    logic [2:0] ptr;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  cmd_grant_arbiter #(
    .NUM_REQ      (5),
    .STARVE_LIMIT (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .look_ahead   (look_ahead),
    .grant_ack    (grant_ack),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .prio_ptr     (prio_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got v=%b oh=%b idx=%0d ptr=%0d, want v=%b oh=%b idx=%0d ptr=%0d", nm,
               got[11], got[10:6], got[5:3], got[2:0], want[11], want[10:6], want[5:3], want[2:0]);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.nm, {grant_valid, grant_onehot, grant_idx, prio_ptr}, {e.v, e.oh, e.idx, e.ptr});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic [4:0] r, input logic la, input logic ack, input logic ev,
                      input int ei, input int ep, input string nm);
    exp_t e;
    req        = r;
    look_ahead = la;
    grant_ack  = ack;
    @(posedge clk);
    e.v   = ev;
    e.oh  = ev ? 5'(1 << ei) : 5'b0;
    e.idx = ev ? 3'(ei) : 3'd0;
    e.ptr = 3'(ep);
    e.nm  = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    look_ahead = 1'b0;
    grant_ack  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {grant_valid, grant_onehot, grant_idx, prio_ptr}, 12'b0);
    rst_n = 1'b1;

    step(5'b00000, 1, 0, 0, 0, 0, "idle_no_req");
    step(5'b10100, 1, 0, 1, 2, 0, "t1_grant");
    step(5'b10100, 1, 0, 1, 2, 0, "t2_hold_a");
    step(5'b10100, 0, 0, 1, 2, 0, "t2_hold_la_low");
    step(5'b10100, 1, 0, 1, 2, 0, "t2_hold_c");
    step(5'b10100, 1, 1, 1, 4, 3, "t2_back_to_back");
    step(5'b01000, 1, 1, 1, 3, 0, "t3_ptr_from4");
    step(5'b10000, 1, 1, 1, 4, 4, "t3_grant4");
    step(5'b00001, 1, 1, 1, 0, 0, "t3_wrap");
    step(5'b00010, 1, 1, 1, 1, 1, "t4_grant1");
    step(5'b00100, 1, 0, 0, 0, 1, "t4_withdraw");
    step(5'b00100, 1, 0, 1, 2, 1, "t4_rearb_after");
    step(5'b00000, 1, 1, 0, 0, 3, "t4_ack_to_idle");
    step(5'b00000, 0, 1, 0, 0, 3, "ack_while_idle");
    repeat (4) step(5'b11111, 0, 0, 0, 0, 3, "t5_blocked");
    // With the guard, four blocked cycles saturate every counter, so index 0 overrides.
    step(5'b11111, 1, 0, 1, Guard ? 0 : 3, 3, "t5_grant_at_ptr");
    step(5'b00000, 0, 1, 0, 0, Guard ? 1 : 4, "ack_beats_withdraw");
    step(5'b00001, 1, 0, 1, 0, Guard ? 1 : 4, "pre_reset_grant");

    #2 rst_n = 1'b0;
    #1 chk("reset_mid_grant", {grant_valid, grant_onehot, grant_idx, prio_ptr}, 12'b0);
    @(negedge clk);
    chk("reset_held", {grant_valid, grant_onehot, grant_idx, prio_ptr}, 12'b0);
    req   = '0;
    rst_n = 1'b1;

    step(5'b01001, 1, 0, 1, 0, 0, "t6_grant0");
    repeat (3) step(5'b01001, 1, 0, 1, 0, 0, "t6_stall");
    step(5'b01011, 1, 1, 1, Guard ? 3 : 1, 1, "t6_after_stall");
    step(5'b00000, 1, 1, 0, 0, Guard ? 4 : 2, "t6_drain");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
